// File: rtl/store_buffer_if.sv
// Pipeline-side and data-memory-side signals of the store buffer.
// The slave modport is the buffer itself; the master modport is the pipeline and memory together.
interface store_buffer_if;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        memwrite;
   logic        memread;
   logic [3:0]  sign_mask;
   logic [31:0] read_data;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [3:0]  mem_sign_mask;
   logic [31:0] mem_read_data;
   logic        mem_clk_stall;

   modport slave (
      input  addr, write_data, memwrite, memread, sign_mask, mem_read_data, mem_clk_stall,
      output read_data, stall, mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
   );

   modport master (
      output addr, write_data, memwrite, memread, sign_mask, mem_read_data, mem_clk_stall,
      input  read_data, stall, mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
   );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: queues pipeline stores in a circular FIFO and drains them to data memory in order.
// Word loads that hit a queued word store are forwarded; other hits wait for the buffer to empty.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   store_buffer_if.slave bus
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t r_state, w_state_next;

   logic [31:0]   r_addr [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [3:0]    r_mask [DEPTH];
   logic [AW-1:0] r_head, r_tail;
   logic [AW:0]   r_count;
   logic [31:0]   r_fwd_data;
   logic          r_fwd_flag;

   logic [AW-1:0]    w_age [DEPTH];
   logic [DEPTH-1:0] w_hit;
   logic [AW-1:0]    w_young, w_young_age;
   logic w_match, w_fwd_ok, w_store, w_load, w_full, w_enq, w_pop;
   logic w_load_fwd, w_load_wait, w_load_pass;
   logic w_stall, w_mem_memwrite, w_mem_memread;
   logic [31:0] w_mem_addr;
   logic [3:0]  w_mem_sign_mask;

   // Age 0 is the head (oldest); an entry is valid when its age is below the count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign w_age[gi] = AW'(gi) - r_head;
         assign w_hit[gi] = ({1'b0, w_age[gi]} < r_count) &&
                            (r_addr[gi][31:2] == bus.addr[31:2]);
      end
   endgenerate

   always_comb begin
      w_young     = '0;
      w_young_age = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_hit[k] && (w_age[k] >= w_young_age)) begin
            w_young     = AW'(k);
            w_young_age = w_age[k];
         end
      end
   end

   assign w_match     = |w_hit;
   assign w_fwd_ok    = w_match && (r_mask[w_young][2:0] == 3'b111) && (bus.sign_mask[2:0] == 3'b111);
   assign w_store     = bus.memwrite;
   assign w_load      = bus.memread && !bus.memwrite;
   assign w_full      = (r_count == FULL_CNT);
   assign w_enq       = w_store && !w_full;
   assign w_pop       = (r_state == S_WAIT) && !bus.mem_clk_stall;
   assign w_load_fwd  = w_load && w_fwd_ok;
   assign w_load_wait = w_load && w_match && !w_fwd_ok;
   assign w_load_pass = w_load && !w_match && (r_state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A load stalled on a non-forwardable hit must not block draining, or it would never complete.
   always_comb begin
      w_state_next    = r_state;
      w_mem_memwrite  = 1'b0;
      w_mem_memread   = 1'b0;
      w_mem_addr      = r_addr[r_head];
      w_mem_sign_mask = r_mask[r_head];
      w_stall         = (w_store && w_full) || (w_load && !w_load_fwd && !w_load_pass);
      case (r_state)
         S_IDLE: begin
            if (w_load_pass) begin
               w_mem_memread   = 1'b1;
               w_mem_addr      = bus.addr;
               w_mem_sign_mask = bus.sign_mask;
            end else if ((r_count != '0) && (!w_load || w_load_wait)) begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_mem_memwrite = 1'b1;
            w_state_next   = S_WAIT;
         end
         S_WAIT: begin
            if (w_pop) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fwd_data <= '0;
         r_fwd_flag <= 1'b0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + AW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + AW'(1);
         end
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_load_fwd) begin
            r_fwd_data <= r_data[w_young];
            r_fwd_flag <= 1'b1;
         end else if (w_load_pass) begin
            r_fwd_flag <= 1'b0;
         end
      end
   end

   // Entry payload needs no reset: validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr[r_tail] <= bus.addr;
         r_data[r_tail] <= bus.write_data;
         r_mask[r_tail] <= bus.sign_mask;
      end
   end

   assign bus.stall          = w_stall;
   assign bus.mem_memwrite   = w_mem_memwrite;
   assign bus.mem_memread    = w_mem_memread;
   assign bus.mem_addr       = w_mem_addr;
   assign bus.mem_sign_mask  = w_mem_sign_mask;
   assign bus.mem_write_data = r_data[r_head];
   assign bus.read_data      = r_fwd_flag ? r_fwd_data : bus.mem_read_data;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stores/loads against a small data-memory model,
// with expected memory writes and load results queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_store_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if bus();
   store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
   wr_t         wq[$];
   logic [31:0] lq[$];
   int tests = 0;
   int fails = 0;
   int rd_pulses = 0;
   logic ld_pend = 1'b0;

   // Data memory model: byte addressed, busy for lat cycles after a write (or while hold).
   logic [31:0] mem [0:255];
   int   busy_cnt = 0;
   int   lat = 1;
   logic hold = 1'b0;
   assign bus.mem_clk_stall = hold || (busy_cnt != 0);

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [1:0] off, input logic [2:0] sz);
      logic [31:0] r;
      r = old;
      case (sz)
         3'b001:  r[8*off +: 8] = d[7:0];
         3'b011:  r[16*off[1] +: 16] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [1:0] off,
                                          input logic [3:0] m);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*off +: 8];
      h = w[16*off[1] +: 16];
      case (m[2:0])
         3'b001:  return m[3] ? {{24{b[7]}}, b} : {24'b0, b};
         3'b011:  return m[3] ? {{16{h[15]}}, h} : {16'b0, h};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.mem_memwrite) begin
         mem[bus.mem_addr[9:2]] <= merge(mem[bus.mem_addr[9:2]], bus.mem_write_data,
                                         bus.mem_addr[1:0], bus.mem_sign_mask[2:0]);
         busy_cnt <= lat;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      if (bus.mem_memread) begin
         bus.mem_read_data <= rd_fmt(mem[bus.mem_addr[9:2]], bus.mem_addr[1:0], bus.mem_sign_mask);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes memory or returns a load result.
   always @(negedge clk) begin
      wr_t w;
      if (!rst_n) begin
         ld_pend = 1'b0;
      end else begin
         if (bus.mem_memread) rd_pulses++;
         if (bus.mem_memwrite) begin
            $display("[TB] mem write addr=0x%08h data=0x%08h mask=%b",
                     bus.mem_addr, bus.mem_write_data, bus.mem_sign_mask);
            if (wq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr 0x%08h, required none", bus.mem_addr);
            end else begin
               w = wq.pop_front();
               check("wr_addr", bus.mem_addr, w.a);
               check("wr_data", bus.mem_write_data, w.d);
               check("wr_mask", {28'b0, bus.mem_sign_mask}, {28'b0, w.m});
            end
         end
         if (ld_pend) begin
            $display("[TB] load result 0x%08h", bus.read_data);
            if (lq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_load: got 0x%08h, required none", bus.read_data);
            end else begin
               check("load_data", bus.read_data, lq.pop_front());
            end
         end
         ld_pend = bus.memread && !bus.memwrite && !bus.stall;
      end
   end

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int stalls);
      bus.addr = a; bus.write_data = d; bus.sign_mask = m;
      bus.memwrite = 1'b1; bus.memread = 1'b0;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         stalls++;
      end
      if (bus.stall) begin
         tests++; fails++;
         $display("FAIL store_timeout: stall still 1 at addr 0x%08h, required 0", a);
      end else begin
         wq.push_back('{a: a, d: d, m: m});
      end
      @(posedge clk); #1;
      bus.memwrite = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp,
                          output int stalls);
      bus.addr = a; bus.sign_mask = m;
      bus.memwrite = 1'b0; bus.memread = 1'b1;
      stalls = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         stalls++;
      end
      if (bus.stall) begin
         tests++; fails++;
         $display("FAIL load_timeout: stall still 1 at addr 0x%08h, required 0", a);
      end else begin
         lq.push_back(exp);
      end
      @(posedge clk); #1;
      bus.memread = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((dut.r_count == 0) && !bus.mem_memwrite) break;
      end
      check("drain_count", 32'(dut.r_count), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int tot;
      int r0;
      int n;
      bus.addr = '0; bus.write_data = '0; bus.memwrite = 1'b0;
      bus.memread = 1'b0; bus.sign_mask = '0;

      // Reset state
      #2;
      check("rst_stall", {31'b0, bus.stall}, 32'd0);
      check("rst_memwrite", {31'b0, bus.mem_memwrite}, 32'd0);
      check("rst_memread", {31'b0, bus.mem_memread}, 32'd0);
      check("rst_count", 32'(dut.r_count), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single word store drains as one write; also preload 0x100 for the pass-through load
      do_store(32'h10, 32'hDEADBEEF, 4'b0111, s);
      check("first_store_no_stall", 32'(s), 32'd0);
      wait_drain();
      do_store(32'h100, 32'hCAFEF00D, 4'b0111, s);
      wait_drain();

      // Five back-to-back stores with memory held busy
      hold = 1'b1;
      tot = 0;
      for (int k = 0; k < 4; k++) begin
         do_store(32'h200 + 32'(4*k), 32'h11111111 * 32'(k+1), 4'b0111, s);
         tot += s;
      end
      check("four_stores_no_stall", 32'(tot), 32'd0);
      bus.addr = 32'h210; bus.write_data = 32'h55555555; bus.sign_mask = 4'b0111;
      bus.memwrite = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("full_stall", {31'b0, bus.stall}, 32'd1);
      end
      hold = 1'b0;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (!bus.stall) break;
         @(negedge clk);
         n++;
      end
      check("fifth_accepted", {31'b0, bus.stall}, 32'd0);
      if (!bus.stall) wq.push_back('{a: 32'h210, d: 32'h55555555, m: 4'b0111});
      @(posedge clk); #1;
      bus.memwrite = 1'b0;
      wait_drain();

      // Word store then word load to the same address forwards without memory access
      r0 = rd_pulses;
      do_store(32'h40, 32'h12345678, 4'b0111, s);
      do_load(32'h40, 4'b1111, 32'h12345678, s);
      check("fwd_no_stall", 32'(s), 32'd0);
      @(negedge clk);
      check("fwd_no_memread", 32'(rd_pulses - r0), 32'd0);
      wait_drain();

      // Byte store then signed byte load: stalls until drained, then sign-extended result
      do_store(32'h41, 32'h000000AB, 4'b0001, s);
      do_load(32'h41, 4'b1001, 32'hFFFFFFAB, s);
      check("byte_load_stalled", {31'b0, s != 0}, 32'd1);
      wait_drain();

      // Queued store plus unrelated load while IDLE: load passes through first
      do_store(32'h80, 32'h0BADC0DE, 4'b0111, s);
      bus.addr = 32'h100; bus.sign_mask = 4'b0111; bus.memread = 1'b1;
      @(negedge clk);
      check("pass_memread", {31'b0, bus.mem_memread}, 32'd1);
      check("pass_addr", bus.mem_addr, 32'h100);
      check("pass_no_write", {31'b0, bus.mem_memwrite}, 32'd0);
      check("pass_no_stall", {31'b0, bus.stall}, 32'd0);
      lq.push_back(32'hCAFEF00D);
      @(posedge clk); #1;
      bus.memread = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (bus.mem_memwrite) break;
      end
      check("drain_after_load_cycles", 32'(n), 32'd2);
      wait_drain();

      // Reset while waiting on memory discards the queue
      hold = 1'b1;
      do_store(32'h300, 32'hA0A0A0A0, 4'b0111, s);
      do_store(32'h304, 32'hB1B1B1B1, 4'b0111, s);
      do_store(32'h308, 32'hC2C2C2C2, 4'b0111, s);
      bus.addr = 32'h200; bus.sign_mask = 4'b0111; bus.memread = 1'b1;
      #2;
      check("wait_load_stall", {31'b0, bus.stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_stall", {31'b0, bus.stall}, 32'd0);
      check("arst_memwrite", {31'b0, bus.mem_memwrite}, 32'd0);
      check("arst_count", 32'(dut.r_count), 32'd0);
      bus.memread = 1'b0;
      wq.delete();
      hold = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_store(32'h400, 32'h44444444, 4'b0111, s);
      check("store_after_reset_no_stall", 32'(s), 32'd0);
      wait_drain();
      repeat (5) @(posedge clk);
      #1;

      check("writes_left", 32'(wq.size()), 32'd0);
      check("loads_left", 32'(lq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of queued stores (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 addr  input  32  pipeline byte address.
REQ-005 write_data  input  32  pipeline store data, right-aligned.
REQ-006 memwrite  input  1  pipeline store request.
REQ-007 memread  input  1  pipeline load request.
REQ-008 sign_mask  input  4  bit3 signed; [2:0] 001 byte, 011 half, 111 word.
REQ-009 read_data  output  32  load result to pipeline.
REQ-010 stall  output  1  holds pipeline; request inputs stay stable while 1.
REQ-011 mem_addr, mem_write_data  output  32 each  to data memory.
REQ-012 mem_memwrite, mem_memread  output  1 each  to data memory.
REQ-013 mem_sign_mask  output  4  to data memory.
REQ-014 mem_read_data  input  32  registered data memory result.
REQ-015 mem_clk_stall  input  1  data memory busy (read-modify-write in progress).

Function
REQ-016 Circular FIFO of DEPTH entries {addr, write_data, sign_mask}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-017 Store with count<DEPTH SHALL enqueue at that clock edge, stall=0; with count==DEPTH, stall=1 combinationally until count<DEPTH.
REQ-018 Full and pop in same cycle: store still stalled that cycle (full evaluated on registered count); enqueue next cycle.
REQ-019 Simultaneous enqueue and pop with count<DEPTH: both occur, count unchanged.
REQ-020 Drain FSM states IDLE, ISSUE, WAIT.
REQ-021 IDLE->ISSUE when count>0 and memread=0.
REQ-022 ISSUE (one cycle): mem_memwrite=1, mem_addr/mem_write_data/mem_sign_mask = head entry; ->WAIT.
REQ-023 WAIT: remain while mem_clk_stall=1; on mem_clk_stall=0 pop head, ->IDLE.
REQ-024 Load match = any valid entry with entry.addr[31:2]==addr[31:2].
REQ-025 Forward: youngest matching entry is word store and load is word -> read_data = that entry data at next edge, stall=0, no memory access.
REQ-026 Match but not forwardable (size mismatch or older-only match): stall=1 until count==0, then pass-through.
REQ-027 No match, FSM IDLE: pass-through -- mem_memread=1, mem_addr=addr, mem_sign_mask=sign_mask same cycle; read_data = mem_read_data after next edge; stall=0.
REQ-028 No match, FSM in ISSUE/WAIT: stall=1 until FSM returns IDLE, then pass-through.
REQ-029 Loads take memory port priority over drain start in IDLE.
REQ-030 memread and memwrite both 1: treated as store only.
REQ-031 read_data = registered forward data when previous accepted load forwarded, else mem_read_data.
REQ-032 mem_memwrite=1 only in ISSUE; mem_memread=0 in ISSUE/WAIT.
REQ-033 Store order to memory SHALL equal acceptance order.

Reset
REQ-034 rst_n=0 asynchronously: count=0, pointers=0, FSM IDLE, stall=0, mem_memwrite=0, mem_memread=0, forward register and flag =0.
REQ-035 Reset during ISSUE/WAIT discards all queued entries; no write completes after reset release.
REQ-036 First edge after rst_n rises SHALL accept a store.

Verification
REQ-037 Reset, store word 0xDEADBEEF @0x10 then memory releases -> one mem_memwrite pulse with addr 0x10, data 0xDEADBEEF, count back to 0.
REQ-038 Five back-to-back word stores, memory busy -> first four accepted, stall=1 on fifth until first pop, fifth enqueued next cycle, memory writes in order.
REQ-039 Store word 0x12345678 @0x40, immediate word load @0x40 -> read_data=0x12345678 next cycle, stall=0, mem_memread never asserted.
REQ-040 Store byte 0xAB @0x41, then signed byte load @0x41 -> stall until drained, then read_data=0xFFFFFFAB.
REQ-041 Queued store @0x80, load @0x100 while FSM IDLE -> load passes through same cycle, drain starts only when memread=0.
REQ-042 Three stores queued, rst_n pulsed low in WAIT -> stall=0, count=0, mem_memwrite=0 immediately, no further memory writes.
